// File: rtl/apb_delayer_pkg.sv
// apb_delayer_pkg: FSM encoding and ratio legality check
// shared by the fractional APB delayer and its counter.
package apb_delayer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_WAIT   = ST_WAIT,
    S_RESP   = ST_RESP
  } state_t;

  function automatic bit ratio_ok(
    input int num,
    input int den
  );
    return (den >= 1) && (num >= den);
  endfunction

endpackage

// File: rtl/apb_delayer_frac_if.sv
// apb_delayer_frac_if: one APB3/4 link; master drives the
// request fields, slave returns ready/data/error.
interface apb_delayer_frac_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic [2:0]        pprot;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pprot,
    output pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pprot,
    input  pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_delay_ratio_cnt.sv
// apb_delay_ratio_cnt: saturating delay accumulator rem and the
// WAIT-entry / WAIT-exit decisions derived from it.
module apb_delay_ratio_cnt
  import apb_delayer_pkg::*;
#(
  parameter int R_NUM = 3,
  parameter int R_DEN = 1,
  parameter int CNT_W = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic dec,
  output logic go_wait,
  output logic wait_done
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(R_NUM - R_DEN);
  localparam logic [CNT_W-1:0] DEN  = CNT_W'(R_DEN);

  logic [CNT_W-1:0] rem;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] inc_val;
  logic [CNT_W-1:0] dec_val;

  // clamp at all-ones instead of wrapping
  assign sum     = {1'b0, rem} + {1'b0, STEP};
  assign inc_val = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  assign dec_val = (rem > DEN) ? rem - DEN : '0;

  assign go_wait   = inc_val > DEN;
  assign wait_done = {1'b0, rem} <= ({1'b0, DEN} << 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0;
    end else if (load) begin
      rem <= STEP;
    end else if (inc) begin
      rem <= inc_val;
    end else if (dec) begin
      rem <= dec_val;
    end
  end

endmodule

// File: rtl/apb_delayer_frac.sv
// apb_delayer_frac: APB pass-through stretching latency by R_NUM/R_DEN.
// Define APB_DELAYER_BYPASS_EN for the per-transfer bypass port.
module apb_delayer_frac
  import apb_delayer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int R_NUM  = 3,
  parameter int R_DEN  = 1,
  parameter int CNT_W  = 32
) (
  input  logic clock,
  input  logic reset,
`ifdef APB_DELAYER_BYPASS_EN
  input  logic bypass,
`endif
  apb_delayer_frac_if.slave  in,
  apb_delayer_frac_if.master out
);

  if (!ratio_ok(R_NUM, R_DEN)) begin : g_bad_ratio
    $error("apb_delayer_frac: need R_DEN >= 1 and R_NUM >= R_DEN");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("apb_delayer_frac: DATA_W must be a multiple of 8");
  end
  if ($bits(in.paddr) != ADDR_W || $bits(in.pwdata) != DATA_W) begin : g_bad_if
    $error("apb_delayer_frac: interface widths differ from ADDR_W/DATA_W");
  end

  state_t            st;
  state_t            st_nxt;
  logic              byp_in;
  logic              byp_q;
  logic              setup;
  logic              acc_done;
  logic              go_wait;
  logic              wait_done;
  logic              pass;
  logic              resp;
  logic              byp_acc;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

`ifdef APB_DELAYER_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  assign setup    = (st == S_IDLE) && in.psel;
  assign acc_done = (st == S_ACCESS) && in.penable && out.pready;

  apb_delay_ratio_cnt #(
    .R_NUM (R_NUM),
    .R_DEN (R_DEN),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .load      (setup && !byp_in),
    .inc       ((st == S_ACCESS) && !byp_q),
    .dec       (st == S_WAIT),
    .go_wait   (go_wait),
    .wait_done (wait_done)
  );

  // a deselect mid-transfer is ignored; only reset aborts
  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:   if (in.psel) st_nxt = S_ACCESS;
      S_ACCESS: begin
        if (in.penable && out.pready) begin
          if (byp_q)        st_nxt = S_IDLE;
          else if (go_wait) st_nxt = S_WAIT;
          else              st_nxt = S_RESP;
        end
      end
      S_WAIT:   if (wait_done) st_nxt = S_RESP;
      S_RESP:   st_nxt = S_IDLE;
      default:  st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st      <= S_IDLE;
      byp_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      st <= st_nxt;
      if (setup) byp_q <= byp_in;
      if (acc_done) begin
        rdata_q <= out.prdata;
        err_q   <= out.pslverr;
      end
    end
  end

  assign pass    = (st == S_IDLE) || (st == S_ACCESS);
  assign resp    = (st == S_RESP);
  assign byp_acc = byp_q && (st == S_ACCESS);

  assign out.paddr   = in.paddr;
  assign out.pprot   = in.pprot;
  assign out.pwrite  = in.pwrite;
  assign out.pwdata  = in.pwdata;
  assign out.pstrb   = in.pstrb;
  assign out.psel    = in.psel && pass;
  assign out.penable = in.penable && pass;

  assign in.pready  = resp || (byp_acc && out.pready);
  assign in.pslverr = resp ? err_q : (byp_acc && out.pslverr);
  assign in.prdata  = resp    ? rdata_q :
                      byp_acc ? out.prdata : '0;

endmodule

// File: tb/tb_apb_delayer_frac.sv
// tb_apb_delayer_frac: directed transfers on 3/1 and 3/2 delayers,
// compared each cycle against a latency-formula model.
`timescale 1ns/1ps
module tb_apb_delayer_frac;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // sel=0 drives dut_a (R=3/1), sel=1 drives dut_b (R=3/2)
  logic        sel = 1'b0;
  logic        m_psel = 1'b0;
  logic        m_penable = 1'b0;
  logic        m_write = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic [2:0]  m_prot = '0;
  logic        d_pready = 1'b0;
  logic        d_pslverr = 1'b0;
  logic [31:0] d_prdata = '0;
  logic        mbyp = 1'b0;

  apb_delayer_frac_if ua ();
  apb_delayer_frac_if da ();
  apb_delayer_frac_if ub ();
  apb_delayer_frac_if db ();

  assign ua.paddr   = m_addr;
  assign ua.pprot   = m_prot;
  assign ua.pwrite  = m_write;
  assign ua.pwdata  = m_wdata;
  assign ua.pstrb   = m_strb;
  assign ua.psel    = m_psel && !sel;
  assign ua.penable = m_penable && !sel;
  assign ub.paddr   = m_addr;
  assign ub.pprot   = m_prot;
  assign ub.pwrite  = m_write;
  assign ub.pwdata  = m_wdata;
  assign ub.pstrb   = m_strb;
  assign ub.psel    = m_psel && sel;
  assign ub.penable = m_penable && sel;
  assign da.pready  = d_pready;
  assign da.prdata  = d_prdata;
  assign da.pslverr = d_pslverr;
  assign db.pready  = d_pready;
  assign db.prdata  = d_prdata;
  assign db.pslverr = d_pslverr;

  apb_delayer_frac #(.R_NUM(3), .R_DEN(1)) dut_a (
    .clock  (clock),
    .reset  (reset),
`ifdef APB_DELAYER_BYPASS_EN
    .bypass (mbyp),
`endif
    .in     (ua),
    .out    (da)
  );

  apb_delayer_frac #(.R_NUM(3), .R_DEN(2)) dut_b (
    .clock  (clock),
    .reset  (reset),
`ifdef APB_DELAYER_BYPASS_EN
    .bypass (mbyp),
`endif
    .in     (ub),
    .out    (db)
  );

  logic        o_pready, o_pslverr, o_psel, o_pen, o_pwrite, o_other;
  logic [31:0] o_prdata, o_paddr, o_pwdata;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;
  assign o_pready  = sel ? ub.pready  : ua.pready;
  assign o_pslverr = sel ? ub.pslverr : ua.pslverr;
  assign o_prdata  = sel ? ub.prdata  : ua.prdata;
  assign o_psel    = sel ? db.psel    : da.psel;
  assign o_pen     = sel ? db.penable : da.penable;
  assign o_paddr   = sel ? db.paddr   : da.paddr;
  assign o_pwdata  = sel ? db.pwdata  : da.pwdata;
  assign o_pwrite  = sel ? db.pwrite  : da.pwrite;
  assign o_pstrb   = sel ? db.pstrb   : da.pstrb;
  assign o_pprot   = sel ? db.pprot   : da.pprot;
  assign o_other   = sel ? ua.pready  : ub.pready;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // upstream cycles from setup to in_pready: max(k+1, ceil(k*num/den))
  function automatic int exp_t(input int num, input int den, input int k);
    int a, b;
    a = k + 1;
    b = (k * num + den - 1) / den;
    return (a > b) ? a : b;
  endfunction

  // model state: cycle index inside the current transfer (0 = idle)
  int          cyc = 0;
  int          mk = 0;
  int          mT = 0;
  logic [31:0] mrd = '0;
  logic        merr = 1'b0;
  logic        chk_on = 1'b0;

  always @(negedge clock) begin : cmp
    logic        ex_rdy, ex_err, live;
    logic [31:0] ex_rd;
    if (chk_on) begin
      live = (cyc != 0);
      ex_rdy = 1'b0;
      ex_err = 1'b0;
      ex_rd = '0;
      if (live && mbyp && cyc >= 2 && cyc <= mk) begin
        ex_rdy = d_pready;
        ex_rd = d_prdata;
        ex_err = d_pslverr;
      end else if (live && !mbyp && cyc == mT) begin
        ex_rdy = 1'b1;
        ex_rd = mrd;
        ex_err = merr;
      end
      chk("in_pready", o_pready, ex_rdy);
      chk("in_prdata", o_prdata, ex_rd);
      chk("in_pslverr", o_pslverr, ex_err);
      chk("out_psel", o_psel, live && cyc <= mk);
      chk("out_penable", o_pen, live && cyc >= 2 && cyc <= mk);
      chk("out_paddr", o_paddr, m_addr);
      chk("out_pwdata", o_pwdata, m_wdata);
      chk("out_pwrite", o_pwrite, m_write);
      chk("out_pstrb", o_pstrb, m_strb);
      chk("out_pprot", o_pprot, m_prot);
      chk("idle_dut_pready", o_other, 1'b0);
    end
  end

  task automatic xfer(
    input  logic        s,
    input  int          k,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] rd,
    input  logic        err,
    input  logic        byp,
    input  int          rst_at,
    output int          t_obs,
    output logic [31:0] rd_obs,
    output logic        err_obs
  );
    sel = s;
    mbyp = byp;
    mk = k;
    mT = byp ? k : exp_t(3, s ? 2 : 1, k);
    mrd = rd;
    merr = err;
    m_addr = addr;
    m_write = wr;
    m_wdata = ~addr;
    m_strb = wr ? 4'hF : 4'h0;
    m_prot = 3'd2;
    m_psel = 1'b1;
    t_obs = 0;
    rd_obs = '0;
    err_obs = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) begin
        @(posedge clock);
        #1;
      end
      cyc = n;
      m_penable = (n >= 2);
      d_pready = (n == k);
      d_prdata = (n == k) ? rd : ~rd;
      d_pslverr = (n == k) && err;
      if (n == rst_at) reset = 1'b1;
      @(negedge clock);
      if (o_pready) begin
        t_obs = n;
        rd_obs = o_prdata;
        err_obs = o_pslverr;
      end
      if (o_pready || n == rst_at) break;
    end
    if (rst_at == 0) chk("xfer_done", t_obs != 0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_psel = 1'b0;
    m_penable = 1'b0;
    cyc = 0;
    mbyp = 1'b0;
    d_pready = 1'b0;
    d_pslverr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          t;
    logic [31:0] rd;
    logic        er;
    @(posedge clock);
    #1;
    chk_on = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);

    xfer(1'b0, 2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, t, rd, er);
    chk("t1_latency", t, 6);
    chk("t1_rdata", rd, 32'hDEAD_BEEF);
    idle(1);

    xfer(1'b1, 2, 1'b0, 32'h0000_2004, 32'h1111_2222, 1'b0, 1'b0, 0, t, rd, er);
    chk("t2_k2_latency", t, 3);
    idle(1);
    xfer(1'b1, 3, 1'b0, 32'h0000_2008, 32'h3333_4444, 1'b0, 1'b0, 0, t, rd, er);
    chk("t2_k3_latency", t, 5);
    idle(1);
    xfer(1'b1, 4, 1'b0, 32'h0000_200C, 32'h5555_6666, 1'b0, 1'b0, 0, t, rd, er);
    chk("t2_k4_latency", t, 6);
    chk("t2_k4_rdata", rd, 32'h5555_6666);
    idle(1);
    xfer(1'b1, 5, 1'b0, 32'h0000_2010, 32'h7777_8888, 1'b0, 1'b0, 0, t, rd, er);
    chk("t2_k5_latency", t, 8);
    idle(2);

    xfer(1'b0, 5, 1'b1, 32'h0000_3000, 32'h0000_0000, 1'b1, 1'b0, 0, t, rd, er);
    chk("t3_latency", t, 15);
    chk("t3_pslverr", er, 1'b1);
    idle(1);

    xfer(1'b0, 3, 1'b0, 32'h0000_4000, 32'h1234_5678, 1'b0, 1'b0, 0, t, rd, er);
    chk("t4_first_latency", t, 9);
    xfer(1'b0, 2, 1'b0, 32'h0000_4004, 32'h9ABC_DEF0, 1'b0, 1'b0, 0, t, rd, er);
    chk("t4_second_latency", t, 6);
    chk("t4_second_rdata", rd, 32'h9ABC_DEF0);
    xfer(1'b1, 2, 1'b0, 32'h0000_4008, 32'h0F0F_0F0F, 1'b1, 1'b0, 0, t, rd, er);
    chk("t4_third_latency", t, 3);
    chk("t4_third_pslverr", er, 1'b1);
    idle(1);

    xfer(1'b0, 2, 1'b0, 32'h0000_5000, 32'hCAFE_F00D, 1'b0, 1'b0, 4, t, rd, er);
    chk("t5_no_ready_before_reset", t, 0);
    idle(1);
    xfer(1'b0, 2, 1'b0, 32'h0000_5004, 32'hA5A5_5A5A, 1'b0, 1'b0, 0, t, rd, er);
    chk("t5_after_reset_latency", t, 6);
    idle(1);

`ifdef APB_DELAYER_BYPASS_EN
    xfer(1'b0, 2, 1'b0, 32'h0000_6000, 32'hB1B2_B3B4, 1'b0, 1'b1, 0, t, rd, er);
    chk("t6_bypass_latency", t, 2);
    chk("t6_bypass_rdata", rd, 32'hB1B2_B3B4);
    idle(1);
    xfer(1'b0, 2, 1'b0, 32'h0000_6004, 32'hC1C2_C3C4, 1'b0, 1'b0, 0, t, rd, er);
    chk("t6_after_bypass_latency", t, 6);
    idle(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
